setup_aie_hls_deadlock_reporter: RTL and testbench

- Consumer end of the HLS deadlock-monitor `block` outputs.
- Receives per-monitor block bits and requires them to persist for CONFIRM_CYCLES consecutive cycles before declaring a deadlock.
- On confirmation, emits exactly one report beat (monitor snapshot, lowest blocked monitor id, timestamp) on a valid/ready handshake, then latches a sticky flag until host clear.
- Sits beside the setup_aie kernel, collecting the block outputs of all idx monitors.

---
 rtl/setup_aie_hls_deadlock_reporter.sv | 145 ++++++++++++++
 tb/tb_setup_aie_hls_deadlock_reporter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/setup_aie_hls_deadlock_reporter.sv
// Deadlock reporter for the setup_aie HLS monitors: confirms persistent block bits and emits one report beat.
// Optional build macro SETUP_AIE_DEADLOCK_COUNT_EN enables the saturating deadlock_count counter.
module setup_aie_hls_deadlock_reporter #(
  parameter int NUM_MON        = 4,
  parameter int CONFIRM_CYCLES = 1024,
  parameter int TS_W           = 32,
  parameter int ID_W           = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [NUM_MON-1:0] report_mask,
  output logic [ID_W-1:0]    report_mon_id,
  output logic [TS_W-1:0]    report_ts,
  output logic               deadlock_flag,
  output logic [7:0]         deadlock_count
);

  localparam int CNT_W = (CONFIRM_CYCLES < 2) ? 1 : $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_MONITOR,
    ST_CONFIRM,
    ST_REPORT,
    ST_LATCHED
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_any_blk;
  logic               w_capture;
  logic [ID_W-1:0]    w_mon_id;
  logic [TS_W-1:0]    r_ts;
  logic [NUM_MON-1:0] r_mask;
  logic [ID_W-1:0]    r_mon_id;
  logic [TS_W-1:0]    r_ts_cap;

  assign w_any_blk = |block_in;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Lowest-index monitor wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    w_mon_id = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (block_in[i]) w_mon_id = ID_W'(i);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_MONITOR;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_MONITOR: begin
          if (w_any_blk) begin
            if (CONFIRM_CYCLES == 1) begin
              w_capture   = 1'b1;
              w_state_nxt = ST_REPORT;
            end else begin
              w_cnt_nxt   = CNT_W'(1);
              w_state_nxt = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (!w_any_blk) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_MONITOR;
          end else if (w_cnt_inc == CNT_W'(CONFIRM_CYCLES)) begin
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
            w_state_nxt = ST_REPORT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_REPORT: begin
          if (report_ready) w_state_nxt = ST_LATCHED;
        end
        ST_LATCHED: w_state_nxt = ST_LATCHED;
        default:    w_state_nxt = ST_MONITOR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_MONITOR;
      r_cnt   <= '0;
      r_ts    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_ts != {TS_W{1'b1}}) r_ts <= r_ts + TS_W'(1);
    end
  end

  // Report fields survive clear; only reset or a new confirmation changes them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mask   <= '0;
      r_mon_id <= '0;
      r_ts_cap <= '0;
    end else if (w_capture) begin
      r_mask   <= block_in;
      r_mon_id <= w_mon_id;
      r_ts_cap <= r_ts;
    end
  end

  assign report_valid  = (r_state == ST_REPORT);
  assign deadlock_flag = (r_state == ST_REPORT) || (r_state == ST_LATCHED);
  assign report_mask   = r_mask;
  assign report_mon_id = r_mon_id;
  assign report_ts     = r_ts_cap;

`ifdef SETUP_AIE_DEADLOCK_COUNT_EN
  logic [7:0] r_dl_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dl_count <= '0;
    end else if (w_capture && (r_dl_count != 8'hFF)) begin
      r_dl_count <= r_dl_count + 8'd1;
    end
  end

  assign deadlock_count = r_dl_count;
`else
  assign deadlock_count = 8'd0;
`endif

endmodule

// File: tb/tb_setup_aie_hls_deadlock_reporter.sv
// Directed self-checking bench for setup_aie_hls_deadlock_reporter (NUM_MON=4, CONFIRM_CYCLES=8),
// plus a second instance with CONFIRM_CYCLES=1 for the single-cycle confirmation boundary.
module tb_setup_aie_hls_deadlock_reporter;

  logic        clock;
  logic        reset;
  logic [3:0]  blk;
  logic        clr;
  logic        rdy;
  logic        valid;
  logic [3:0]  mask;
  logic [4:0]  mon_id;
  logic [31:0] ts;
  logic        flag;
  logic [7:0]  count;

  logic [3:0]  blk1;
  logic        clr1;
  logic        rdy1;
  logic        valid1;
  logic [3:0]  mask1;
  logic [4:0]  mon_id1;
  logic [31:0] ts1;
  logic        flag1;
  logic [7:0]  count1;

  int          checks;
  int          errors;
  logic [31:0] edges;
  logic [31:0] ts_exp;
  logic [31:0] prev_ts;

  setup_aie_hls_deadlock_reporter #(
    .NUM_MON(4), .CONFIRM_CYCLES(8), .TS_W(32), .ID_W(5)
  ) dut (
    .clock(clock), .reset(reset), .block_in(blk), .clear(clr),
    .report_valid(valid), .report_ready(rdy), .report_mask(mask),
    .report_mon_id(mon_id), .report_ts(ts), .deadlock_flag(flag),
    .deadlock_count(count)
  );

  setup_aie_hls_deadlock_reporter #(
    .NUM_MON(4), .CONFIRM_CYCLES(1), .TS_W(32), .ID_W(5)
  ) dut1 (
    .clock(clock), .reset(reset), .block_in(blk1), .clear(clr1),
    .report_valid(valid1), .report_ready(rdy1), .report_mask(mask1),
    .report_mon_id(mon_id1), .report_ts(ts1), .deadlock_flag(flag1),
    .deadlock_count(count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference timestamp: posedges seen since reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) edges <= 32'd0;
    else if (edges != 32'hFFFF_FFFF) edges <= edges + 32'd1;
  end

  task automatic test_reset();
    reset = 1'b0;
    blk = 4'b0; clr = 1'b0; rdy = 1'b0;
    blk1 = 4'b0; clr1 = 1'b0; rdy1 = 1'b0;
    #2;
    checks++;
    if ({valid, flag, mask, mon_id, ts, count} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b f=%b m=%h id=%0d ts=%0d c=%0d required all zero",
               valid, flag, mask, mon_id, ts, count);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic_report();
    blk = 4'b0100; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ts_exp = edges;
      checks++;
      if (valid !== 1'b0) begin
        errors++; $display("FAIL basic_early_valid: cycle %0d got %b required 0", i, valid);
      end
      @(negedge clock);
    end
    checks++;
    if (valid !== 1'b1 || flag !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got v=%b f=%b required v=1 f=1", valid, flag);
    end
    checks++;
    if (mask !== 4'b0100 || mon_id !== 5'd2) begin
      errors++; $display("FAIL basic_fields: got mask=%b id=%0d required 0100 2", mask, mon_id);
    end
    checks++;
    if (ts !== ts_exp || ts_exp !== 32'd7) begin
      errors++; $display("FAIL basic_ts: got %0d required %0d (hand value 7)", ts, ts_exp);
    end
    blk = 4'b0;
    @(negedge clock);
    checks++;
    if (valid !== 1'b0 || flag !== 1'b1) begin
      errors++; $display("FAIL basic_pulse: got v=%b f=%b required v=0 f=1", valid, flag);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (flag !== 1'b1) begin
      errors++; $display("FAIL basic_sticky: got %b required 1", flag);
    end
  endtask

  task automatic test_idle_gap();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checks++;
    if (flag !== 1'b0) begin
      errors++; $display("FAIL gap_clear: got flag=%b required 0", flag);
    end
    for (int i = 0; i < 15; i++) begin
      blk = (i == 7) ? 4'b0000 : 4'b0010;
      @(negedge clock);
      checks++;
      if (valid !== 1'b0 || flag !== 1'b0) begin
        errors++; $display("FAIL gap_no_report: cycle %0d got v=%b f=%b required 0 0", i, valid, flag);
      end
    end
    blk = 4'b0;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    rdy = 1'b0; blk = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ts_exp = edges;
      @(negedge clock);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (valid !== 1'b1 || mask !== 4'b1010 || mon_id !== 5'd1 || ts !== ts_exp) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b m=%b id=%0d ts=%0d required 1 1010 1 %0d",
                 i, valid, mask, mon_id, ts, ts_exp);
      end
      blk = 4'b0;
      rdy = (i == 5);
      @(negedge clock);
    end
    checks++;
    if (valid !== 1'b0 || flag !== 1'b1) begin
      errors++; $display("FAIL bp_latched: got v=%b f=%b required 0 1", valid, flag);
    end
    blk = 4'b1010;
    repeat (10) @(negedge clock);
    checks++;
    if (valid !== 1'b0 || flag !== 1'b1 || mask !== 4'b1010 || ts !== ts_exp) begin
      errors++;
      $display("FAIL latched_ignore: got v=%b f=%b m=%b ts=%0d required 0 1 1010 %0d",
               valid, flag, mask, ts, ts_exp);
    end
    prev_ts = ts_exp;
  endtask

  task automatic test_clear_rearm();
    blk = 4'b0001; clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checks++;
    if (flag !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rearm_clear: got f=%b v=%b required 0 0", flag, valid);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ts_exp = edges;
      checks++;
      if (valid !== 1'b0) begin
        errors++; $display("FAIL rearm_early: cycle %0d got v=%b required 0", i, valid);
      end
      @(negedge clock);
    end
    checks++;
    if (valid !== 1'b1 || mon_id !== 5'd0 || mask !== 4'b0001 || ts !== ts_exp || !(ts > prev_ts)) begin
      errors++;
      $display("FAIL rearm_report: got v=%b id=%0d m=%b ts=%0d required 1 0 0001 %0d (> %0d)",
               valid, mon_id, mask, ts, ts_exp, prev_ts);
    end
    blk = 4'b0;
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0; blk = 4'b0100; rdy = 1'b0;
    repeat (8) @(negedge clock);
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL areset_setup: got v=%b required 1", valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || flag !== 1'b0 || mask !== 4'b0 || ts !== 32'd0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b f=%b m=%b ts=%0d required 0 0 0000 0", valid, flag, mask, ts);
    end
    @(negedge clock);
    reset = 1'b1; rdy = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (valid !== 1'b1 || ts !== 32'd7 || mask !== 4'b0100) begin
      errors++; $display("FAIL areset_ts_restart: got v=%b ts=%0d m=%b required 1 7 0100", valid, ts, mask);
    end
  endtask

  task automatic test_clear_with_handshake();
    // Still in REPORT with rdy=1: clear and handshake coincide.
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checks++;
    if (valid !== 1'b0 || flag !== 1'b0) begin
      errors++; $display("FAIL clear_hs: got v=%b f=%b required 0 0", valid, flag);
    end
    blk = 4'b0;
    @(negedge clock);
  endtask

  task automatic test_count();
    logic [7:0] exp_count;
`ifdef SETUP_AIE_DEADLOCK_COUNT_EN
    exp_count = 8'd3;
`else
    exp_count = 8'd0;
`endif
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0) begin
      errors++; $display("FAIL count_reset: got %0d required 0", count);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      blk = 4'b0010; rdy = 1'b1;
      repeat (8) @(negedge clock);
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL count_report: round %0d got v=%b required 1", k, valid);
      end
      blk = 4'b0; clr = 1'b1;
      @(negedge clock);
      clr = 1'b0;
    end
    checks++;
    if (count !== exp_count) begin
      errors++; $display("FAIL deadlock_count: got %0d required %0d", count, exp_count);
    end
  endtask

  task automatic test_confirm_one();
    clr1 = 1'b1;
    @(negedge clock);
    clr1 = 1'b0; rdy1 = 1'b1; blk1 = 4'b1000;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++; $display("FAIL c1_idle: got v=%b required 0", valid1);
    end
    @(negedge clock);
    blk1 = 4'b0;
    checks++;
    if (valid1 !== 1'b1 || mask1 !== 4'b1000 || mon_id1 !== 5'd3) begin
      errors++; $display("FAIL c1_report: got v=%b m=%b id=%0d required 1 1000 3", valid1, mask1, mon_id1);
    end
    @(negedge clock);
    checks++;
    if (valid1 !== 1'b0 || flag1 !== 1'b1) begin
      errors++; $display("FAIL c1_latched: got v=%b f=%b required 0 1", valid1, flag1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_ts = 32'd0;
    ts_exp = 32'd0;
    test_reset();
    test_basic_report();
    test_idle_gap();
    test_backpressure();
    test_clear_rearm();
    test_async_reset();
    test_clear_with_handshake();
    test_count();
    test_confirm_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
